// File: rtl/gost_round_ctrl.sv
// GOST 28147-89 round sequencer: holds N1/N2, drives an external round function for 32 Feistel rounds.
// Optional build macro GOST_ROUND_CTRL_PIPE_EN registers iround_f, so each round takes two cycles.
module gost_round_ctrl (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        istart,
  input  logic        idecrypt,
  input  logic [63:0] idata,
  output logic        oready,
  output logic        obusy,
  output logic [2:0]  ok_idx,
  output logic [31:0] on1,
  input  logic [31:0] iround_f,
  output logic [63:0] odata,
  output logic        ovalid
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  round_q, round_d;
  logic [31:0] n1_q, n1_d;
  logic [31:0] n2_q, n2_d;
  logic        dec_q, dec_d;
  logic [31:0] fVal;
  logic        roundEn;
  logic        fwdOrder;

`ifdef GOST_ROUND_CTRL_PIPE_EN
  logic [31:0] f_q, f_d;
  logic        phase_q, phase_d;

  // Phase 0 captures f into f_q, phase 1 applies it; on1/ok_idx do not move in between.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      f_q     <= 32'd0;
      phase_q <= 1'b0;
    end else begin
      f_q     <= f_d;
      phase_q <= phase_d;
    end
  end

  assign fVal    = f_q;
  assign roundEn = phase_q;
`else
  assign fVal    = iround_f;
  assign roundEn = 1'b1;
`endif

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= IDLE;
      round_q <= 5'd0;
      n1_q    <= 32'd0;
      n2_q    <= 32'd0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    dec_d   = dec_q;
`ifdef GOST_ROUND_CTRL_PIPE_EN
    f_d     = f_q;
    phase_d = phase_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (istart) begin
          n1_d    = idata[31:0];
          n2_d    = idata[63:32];
          dec_d   = idecrypt;
          round_d = 5'd0;
          state_d = RUN;
`ifdef GOST_ROUND_CTRL_PIPE_EN
          phase_d = 1'b0;
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
`ifdef GOST_ROUND_CTRL_PIPE_EN
        f_d     = phase_q ? f_q : iround_f;
        phase_d = ~phase_q;
`endif
        // The last round folds f into N2 and skips the swap.
        if (roundEn) begin
          if (round_q == 5'd31) begin
            n2_d    = n2_q ^ fVal;
            state_d = DONE;
          end else begin
            n1_d    = n2_q ^ fVal;
            n2_d    = n1_q;
            round_d = round_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Forward subkey order for 24 rounds (encrypt) or 8 rounds (decrypt), then reversed.
  assign fwdOrder = dec_q ? (round_q < 5'd8) : (round_q < 5'd24);
  assign ok_idx   = (state_q == RUN) ? (fwdOrder ? round_q[2:0] : ~round_q[2:0]) : 3'd0;

  assign oready = (state_q != RUN);
  assign obusy  = (state_q == RUN);
  assign ovalid = (state_q == DONE);
  assign on1    = n1_q;
  assign odata  = {n2_q, n1_q};

endmodule

// File: tb/tb_gost_round_ctrl.sv
// Randomised self-checking bench for gost_round_ctrl against a per-block trace model.
module tb_gost_round_ctrl;

`ifdef GOST_ROUND_CTRL_PIPE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int LAT   = 32 * STEP + 1;
  localparam int LIMIT = 200;

  localparam int ENC_ORDER [32] = '{0,1,2,3,4,5,6,7, 0,1,2,3,4,5,6,7,
                                    0,1,2,3,4,5,6,7, 7,6,5,4,3,2,1,0};
  localparam int DEC_ORDER [32] = '{0,1,2,3,4,5,6,7, 7,6,5,4,3,2,1,0,
                                    7,6,5,4,3,2,1,0, 7,6,5,4,3,2,1,0};

  logic        iclk = 1'b0;
  logic        irst_n = 1'b0;
  logic        istart = 1'b0;
  logic        idecrypt = 1'b0;
  logic [63:0] idata = 64'd0;
  logic        oready, obusy, ovalid;
  logic [2:0]  ok_idx;
  logic [31:0] on1, iround_f;
  logic [63:0] odata;

  int total = 0;
  int bad = 0;
  int fMode = 0;

  gost_round_ctrl dut (
    .iclk(iclk), .irst_n(irst_n), .istart(istart), .idecrypt(idecrypt),
    .idata(idata), .oready(oready), .obusy(obusy), .ok_idx(ok_idx),
    .on1(on1), .iround_f(iround_f), .odata(odata), .ovalid(ovalid)
  );

  always #5 iclk = ~iclk;

  function automatic logic [31:0] fFunc(input int mode, input logic [31:0] n1, input logic [2:0] k);
    logic [31:0] kw;
    kw = {29'd0, k};
    case (mode)
      1:       return n1 + kw * 32'h01010101;
      2:       return ({n1[20:0], n1[31:21]} + kw * 32'h9E3779B9) ^ 32'hA5A5A5A5;
      default: return 32'd0;
    endcase
  endfunction

  assign iround_f = fFunc(fMode, on1, ok_idx);

  // Model: on acceptance the whole 32-round trace is computed; elapsed cycles select the round.
  int          mState = 0;
  int          mT = 0;
  logic [31:0] heldN1 = 32'd0, heldN2 = 32'd0;
  logic [31:0] trN1 [33];
  logic [31:0] trN2 [33];
  logic [2:0]  trKey [32];
  logic [2:0]  dutKeys [32];

  task automatic loadModel(input logic [63:0] data, input logic dec);
    logic [31:0] f;
    trN1[0] = data[31:0];
    trN2[0] = data[63:32];
    for (int r = 0; r < 32; r++)
      trKey[r] = 3'((r < (dec ? 8 : 24)) ? (r % 8) : (7 - r % 8));
    for (int r = 0; r < 32; r++) begin
      f = fFunc(fMode, trN1[r], trKey[r]);
      if (r < 31) begin
        trN1[r+1] = trN2[r] ^ f;
        trN2[r+1] = trN1[r];
      end else begin
        trN2[32] = trN2[31] ^ f;
        trN1[32] = trN1[31];
      end
    end
  endtask

  always @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      mState = 0;
      mT     = 0;
      heldN1 = 32'd0;
      heldN2 = 32'd0;
    end else if (mState == 1) begin
      mT = mT + 1;
      if (mT == 32 * STEP) begin
        mState = 2;
        heldN1 = trN1[32];
        heldN2 = trN2[32];
      end
    end else if (istart) begin
      loadModel(idata, idecrypt);
      mState = 1;
      mT     = 0;
    end else begin
      mState = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge iclk) begin
    int rr;
    if (irst_n === 1'b1) begin
      if (mState == 1) begin
        rr = mT / STEP;
        dutKeys[rr] = ok_idx;
        checkOutput("ok_idx", 64'(ok_idx), 64'(trKey[rr]));
        checkOutput("on1", 64'(on1), 64'(trN1[rr]));
        checkOutput("odata_run", odata, {trN2[rr], trN1[rr]});
      end else begin
        checkOutput("ok_idx_idle", 64'(ok_idx), 64'd0);
        checkOutput("on1_idle", 64'(on1), 64'(heldN1));
        checkOutput("odata", odata, {heldN2, heldN1});
      end
      checkOutput("oready", 64'(oready), 64'(mState != 1));
      checkOutput("obusy", 64'(obusy), 64'(mState == 1));
      checkOutput("ovalid", 64'(ovalid), 64'(mState == 2));
    end
  end

  // Issues one block and returns at the negedge where ovalid is seen; busyAt>0 pulses istart mid-run.
  task automatic applyStimulus(input logic [63:0] data, input logic dec, input int busyAt,
                               output logic [63:0] result, output int lat);
    istart   = 1'b1;
    idata    = data;
    idecrypt = dec;
    @(negedge iclk);
    istart   = 1'b0;
    idata    = {$urandom, $urandom};
    idecrypt = 1'($urandom);
    lat = 1;
    while (ovalid !== 1'b1 && lat < LIMIT) begin
      if (lat == busyAt) begin
        istart = 1'b1;
        idata  = {$urandom, $urandom};
      end else begin
        istart = 1'b0;
      end
      @(negedge iclk);
      lat++;
    end
    istart = 1'b0;
    if (lat >= LIMIT) begin
      bad++;
      $display("[TB] FAIL timeout: no ovalid after %0d cycles, required %0d", lat, LAT);
    end
    result = odata;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge iclk);
  endtask

  task automatic checkKeys(input logic dec);
    for (int r = 0; r < 32; r++)
      checkOutput(dec ? "dec_order" : "enc_order", 64'(dutKeys[r]),
                  64'(dec ? DEC_ORDER[r] : ENC_ORDER[r]));
  endtask

  initial begin
    logic [63:0] res, ct;
    int lat;
    int fixed [3];
    $display("[TB] start, STEP=%0d", STEP);
    #12 irst_n = 1'b1;
    @(negedge iclk);
    checkOutput("reset_ready", 64'(oready), 64'd1);
    checkOutput("reset_odata", odata, 64'd0);

    // Reset in the middle of round 10, then a clean run.
    fMode = 1;
    istart = 1'b1;
    idata  = 64'h0123_4567_89AB_CDEF;
    @(negedge iclk);
    istart = 1'b0;
    idleCycles(10 * STEP);
    #2 irst_n = 1'b0;
    #1;
    checkOutput("rst_oready", 64'(oready), 64'd1);
    checkOutput("rst_obusy", 64'(obusy), 64'd0);
    checkOutput("rst_ovalid", 64'(ovalid), 64'd0);
    checkOutput("rst_ok_idx", 64'(ok_idx), 64'd0);
    checkOutput("rst_on1", 64'(on1), 64'd0);
    checkOutput("rst_odata", odata, 64'd0);
    @(negedge iclk);
    #2 irst_n = 1'b1;
    @(negedge iclk);
    applyStimulus(64'h0000_0002_0000_0001, 1'b0, 0, res, lat);
    checkOutput("latency_after_reset", 64'(lat), 64'(LAT));
    idleCycles(2);

    // Zero round function: 31 swaps leave the halves exchanged.
    fMode = 0;
    applyStimulus(64'hBBBB_BBBB_AAAA_AAAA, 1'b0, 0, res, lat);
    checkOutput("zero_f_result", res, 64'hAAAA_AAAA_BBBB_BBBB);
    checkOutput("zero_f_latency", 64'(lat), 64'(LAT));
    checkKeys(1'b0);
    idleCycles(1);
    applyStimulus(64'h1111_2222_3333_4444, 1'b1, 0, res, lat);
    checkKeys(1'b1);
    idleCycles(3);

    // Round trip, then a busy-ignored pulse at round 5 and a back-to-back block.
    fMode = 1;
    applyStimulus(64'h0123_4567_89AB_CDEF, 1'b0, 0, ct, lat);
    idleCycles(2);
    applyStimulus(ct, 1'b1, 5 * STEP + 1, res, lat);
    checkOutput("round_trip", res, 64'h0123_4567_89AB_CDEF);
    applyStimulus(64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0, res, lat);
    checkOutput("back_to_back_latency", 64'(lat), 64'(LAT - 1 + 1));

    // Random blocks with random functions, modes, gaps and ignored mid-run starts.
    fixed = '{0, 1, 2};
    for (int i = 0; i < 12; i++) begin
      idleCycles($urandom_range(0, 3));
      fMode = fixed[$urandom_range(0, 2)];
      applyStimulus({$urandom, $urandom}, 1'($urandom), $urandom_range(2, 30 * STEP), res, lat);
      checkOutput("rand_latency", 64'(lat), 64'(LAT));
    end
    idleCycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
